// File: rtl/miner_result_tx_if.sv
// Hasher-to-reporter bundle: solution inputs plus the UART
// frame status returned to the system.
interface miner_result_tx_if;
    logic        sol_valid;
    logic [31:0] sol_time;
    logic [31:0] sol_nonce;
    logic        tx;
    logic        busy;
    logic        frame_done;
    logic [7:0]  drop_count;

    modport master (
        output sol_valid, sol_time, sol_nonce,
        input  tx, busy, frame_done, drop_count
    );

    modport slave (
        input  sol_valid, sol_time, sol_nonce,
        output tx, busy, frame_done, drop_count
    );
endinterface

// File: rtl/miner_result_tx.sv
// Captures a hasher solution on the rising edge of sol_valid and sends
// it as a 10-byte UART 8N1 frame: sync, nonce, time, XOR checksum.
module miner_result_tx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic CLK,
    input  logic RST,
    miner_result_tx_if.slave bus
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] RELOAD = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, DONE
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [3:0]    byte_idx;
    logic [2:0]    bit_idx;
    logic [7:0]    sh_q;
    logic [31:0]   nonce_q;
    logic [31:0]   time_q;
    logic [7:0]    csum_q;
    logic          valid_q;
    logic          tx_q;
    logic          busy_q;
    logic          done_q;
    logic [7:0]    drops_q;

    logic       capture;
    logic       idle_like;
    logic [7:0] csum_in;
    logic [7:0] next_byte;

    assign capture   = bus.sol_valid & ~valid_q;
    assign idle_like = (state == IDLE) || (state == DONE);

    assign csum_in = bus.sol_nonce[31:24] ^ bus.sol_nonce[23:16]
                   ^ bus.sol_nonce[15:8]  ^ bus.sol_nonce[7:0]
                   ^ bus.sol_time[31:24]  ^ bus.sol_time[23:16]
                   ^ bus.sol_time[15:8]   ^ bus.sol_time[7:0];

    // Byte that follows the one at byte_idx
    always_comb begin
        next_byte = csum_q;
        case (byte_idx)
            4'd0:    next_byte = nonce_q[31:24];
            4'd1:    next_byte = nonce_q[23:16];
            4'd2:    next_byte = nonce_q[15:8];
            4'd3:    next_byte = nonce_q[7:0];
            4'd4:    next_byte = time_q[31:24];
            4'd5:    next_byte = time_q[23:16];
            4'd6:    next_byte = time_q[15:8];
            4'd7:    next_byte = time_q[7:0];
            default: next_byte = csum_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            timer    <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            sh_q     <= '0;
            nonce_q  <= '0;
            time_q   <= '0;
            csum_q   <= '0;
            valid_q  <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            drops_q  <= '0;
        end else begin
            valid_q <= bus.sol_valid;
            done_q  <= 1'b0;
            if (capture && !idle_like && drops_q != 8'hFF)
                drops_q <= drops_q + 8'd1;
            case (state)
                IDLE, DONE: begin
                    state  <= IDLE;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (capture) begin
                        nonce_q  <= bus.sol_nonce;
                        time_q   <= bus.sol_time;
                        csum_q   <= csum_in;
                        sh_q     <= SYNC_BYTE;
                        byte_idx <= '0;
                        timer    <= RELOAD;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (timer == '0) begin
                        timer   <= RELOAD;
                        tx_q    <= sh_q[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                DATA: begin
                    if (timer == '0) begin
                        timer <= RELOAD;
                        if (bit_idx == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx_q    <= sh_q[1];
                            sh_q    <= {1'b0, sh_q[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                STOP: begin
                    if (timer == '0) begin
                        if (byte_idx == 4'd9) begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= DONE;
                        end else begin
                            timer    <= RELOAD;
                            byte_idx <= byte_idx + 4'd1;
                            sh_q     <= next_byte;
                            tx_q     <= 1'b0;
                            state    <= START;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign bus.drop_count = drops_q;
endmodule

// File: tb/tb_miner_result_tx.sv
// Directed bench for miner_result_tx with CLKS_PER_BIT=4:
// frames decoded from tx by bit-centre sampling.
module tb_miner_result_tx;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    miner_result_tx_if bus ();

    miner_result_tx #(.CLKS_PER_BIT(4), .SYNC_BYTE(8'hA5)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.slave)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    bit   rx_raw [0:99];
    logic [79:0] rx_bytes;
    int   rx_wait;
    bit   rx_timeout;
    bit   rx_fd_early;
    bit   rx_frame_ok;
    logic rx_fd_end;
    logic rx_busy_end;
    logic rx_busy_mid;

    // Waits for the start bit, then samples the middle of each of the
    // 100 bit times; returns on the cycle right after the last stop bit.
    task automatic rx_frame(input int maxw);
        rx_timeout = 1'b1;
        rx_wait = 0;
        for (int i = 0; i < maxw; i++) begin
            @(negedge CLK);
            rx_wait++;
            if (bus.tx === 1'b0) begin
                rx_timeout = 1'b0;
                break;
            end
        end
        rx_bytes = '0;
        rx_frame_ok = 1'b0;
        if (rx_timeout) return;
        rx_fd_early = 1'b0;
        for (int off = 0; off <= 400; off++) begin
            if (off > 0) @(negedge CLK);
            if (off < 400 && bus.frame_done !== 1'b0) rx_fd_early = 1'b1;
            if (off % 4 == 1) rx_raw[off / 4] = bus.tx;
            if (off == 200) rx_busy_mid = bus.busy;
        end
        rx_fd_end = bus.frame_done;
        rx_busy_end = bus.busy;
        rx_frame_ok = 1'b1;
        for (int b = 0; b < 10; b++) begin
            if (rx_raw[10*b] != 1'b0 || rx_raw[10*b+9] != 1'b1)
                rx_frame_ok = 1'b0;
            for (int j = 0; j < 8; j++)
                rx_bytes[72 - 8*b + j] = rx_raw[10*b + 1 + j];
        end
    endtask

    task automatic do_reset();
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_reset();
        bus.sol_valid = 1'b0;
        bus.sol_time = '0;
        bus.sol_nonce = '0;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        vectors++;
        if (bus.tx !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_tx got %b want 1", bus.tx);
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy got %b want 0", bus.busy);
        end
        vectors++;
        if (bus.frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done got %b want 0", bus.frame_done);
        end
        vectors++;
        if (bus.drop_count !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_drops got %0d want 0", bus.drop_count);
        end
        RST = 1'b1;
        repeat (5) @(negedge CLK);
        vectors++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset tx=%b busy=%b want 1/0",
                     bus.tx, bus.busy);
        end
    endtask

    task automatic test_basic();
        @(negedge CLK);
        bus.sol_nonce = 32'h0000_0001;
        bus.sol_time = 32'h0000_0000;
        bus.sol_valid = 1'b1;
        fork
            rx_frame(10);
            begin
                @(negedge CLK);
                bus.sol_valid = 1'b0;
            end
        join
        vectors++;
        if (rx_timeout || rx_wait != 1) begin
            miscompares++;
            $display("FAIL basic_latency timeout=%b wait=%0d want 0/1",
                     rx_timeout, rx_wait);
        end
        vectors++;
        if (rx_bytes !== 80'hA5_00000001_00000000_01) begin
            miscompares++;
            $display("FAIL basic_bytes got %h want a50000000100000000 01",
                     rx_bytes);
        end
        vectors++;
        if (!rx_frame_ok) begin
            miscompares++;
            $display("FAIL basic_framing got bad start/stop want ok");
        end
        vectors++;
        if (rx_fd_early || rx_fd_end !== 1'b1 || rx_busy_end !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done early=%b end=%b busy=%b want 0/1/0",
                     rx_fd_early, rx_fd_end, rx_busy_end);
        end
        vectors++;
        if (rx_busy_mid !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_busy_mid got %b want 1", rx_busy_mid);
        end
        @(negedge CLK);
        vectors++;
        if (bus.frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done_width got %b want 0", bus.frame_done);
        end
    endtask

    task automatic test_bits();
        bit exp_b1 [0:9];
        bit ok;
        exp_b1 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        @(negedge CLK);
        bus.sol_nonce = 32'h1234_5678;
        bus.sol_time = 32'h9ABC_DEF0;
        bus.sol_valid = 1'b1;
        fork
            rx_frame(10);
            begin
                @(negedge CLK);
                bus.sol_valid = 1'b0;
            end
        join
        vectors++;
        if (rx_timeout || rx_bytes !== 80'hA5_12345678_9ABCDEF0_00) begin
            miscompares++;
            $display("FAIL bits_bytes got %h want a5123456789abcdef000",
                     rx_bytes);
        end
        ok = 1'b1;
        for (int i = 0; i < 10; i++)
            if (rx_raw[10 + i] != exp_b1[i]) ok = 1'b0;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL bits_lsb_first byte 0x12 serial order wrong want 0,0,1,0,0,1,0,0,0,1");
        end
        @(negedge CLK);
    endtask

    task automatic test_hold();
        int dones = 0;
        @(negedge CLK);
        bus.sol_nonce = 32'h0BAD_F00D;
        bus.sol_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            if (bus.frame_done === 1'b1) dones++;
        end
        bus.sol_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (bus.frame_done === 1'b1) dones++;
        end
        vectors++;
        if (dones != 1) begin
            miscompares++;
            $display("FAIL hold_frames got %0d want 1", dones);
        end
        vectors++;
        if (bus.drop_count !== 8'd0) begin
            miscompares++;
            $display("FAIL hold_drops got %0d want 0", bus.drop_count);
        end
    endtask

    task automatic test_drops();
        @(negedge CLK);
        bus.sol_nonce = 32'hDEAD_BEEF;
        bus.sol_time = 32'h0000_0010;
        bus.sol_valid = 1'b1;
        fork
            rx_frame(10);
            begin
                @(negedge CLK);
                bus.sol_valid = 1'b0;
                repeat (40) @(negedge CLK);
                bus.sol_nonce = 32'h1111_2222;
                bus.sol_time = 32'h3333_4444;
                for (int i = 0; i < 3; i++) begin
                    bus.sol_valid = 1'b1;
                    @(negedge CLK);
                    bus.sol_valid = 1'b0;
                    @(negedge CLK);
                end
            end
        join
        vectors++;
        if (rx_timeout || rx_bytes !== 80'hA5_DEADBEEF_00000010_32) begin
            miscompares++;
            $display("FAIL drops_first_data got %h want a5deadbeef0000001032",
                     rx_bytes);
        end
        vectors++;
        if (bus.drop_count !== 8'd3) begin
            miscompares++;
            $display("FAIL drops_three got %0d want 3", bus.drop_count);
        end
        for (int i = 0; i < 600; i++) begin
            bus.sol_valid = 1'b1;
            @(negedge CLK);
            bus.sol_valid = 1'b0;
            @(negedge CLK);
        end
        vectors++;
        if (bus.drop_count !== 8'd255) begin
            miscompares++;
            $display("FAIL drops_saturate got %0d want 255", bus.drop_count);
        end
        repeat (500) @(negedge CLK);
    endtask

    task automatic test_done_edge();
        do_reset();
        @(negedge CLK);
        bus.sol_nonce = 32'h0000_0001;
        bus.sol_time = 32'h0000_0000;
        bus.sol_valid = 1'b1;
        fork
            rx_frame(10);
            begin
                @(negedge CLK);
                bus.sol_valid = 1'b0;
            end
        join
        vectors++;
        if (rx_timeout || rx_fd_end !== 1'b1) begin
            miscompares++;
            $display("FAIL done_first timeout=%b done=%b want 0/1",
                     rx_timeout, rx_fd_end);
        end
        bus.sol_nonce = 32'h0000_00FF;
        bus.sol_time = 32'h0100_0000;
        bus.sol_valid = 1'b1;
        rx_frame(5);
        bus.sol_valid = 1'b0;
        vectors++;
        if (rx_timeout || rx_wait != 1) begin
            miscompares++;
            $display("FAIL done_edge_start timeout=%b wait=%0d want 0/1",
                     rx_timeout, rx_wait);
        end
        vectors++;
        if (rx_bytes !== 80'hA5_000000FF_01000000_FE) begin
            miscompares++;
            $display("FAIL done_edge_bytes got %h want a5000000ff01000000fe",
                     rx_bytes);
        end
        vectors++;
        if (bus.drop_count !== 8'd0) begin
            miscompares++;
            $display("FAIL done_edge_drops got %0d want 0", bus.drop_count);
        end
        repeat (5) @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        bit fd_seen = 1'b0;
        @(negedge CLK);
        bus.sol_nonce = 32'hCAFE_F00D;
        bus.sol_time = 32'h0000_0001;
        bus.sol_valid = 1'b1;
        @(negedge CLK);
        bus.sol_valid = 1'b0;
        repeat (50) @(negedge CLK);
        bus.sol_valid = 1'b1;
        repeat (120) @(negedge CLK);
        vectors++;
        if (bus.drop_count !== 8'd1 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_pre drops=%0d busy=%b want 1/1",
                     bus.drop_count, bus.busy);
        end
        #2 RST = 1'b0;
        #1;
        vectors++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.drop_count !== 8'd0) begin
            miscompares++;
            $display("FAIL midrst_async tx=%b busy=%b drops=%0d want 1/0/0",
                     bus.tx, bus.busy, bus.drop_count);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (bus.frame_done !== 1'b0) fd_seen = 1'b1;
        end
        RST = 1'b1;
        rx_frame(5);
        bus.sol_valid = 1'b0;
        vectors++;
        if (fd_seen || rx_timeout || rx_wait != 1) begin
            miscompares++;
            $display("FAIL midrst_restart fd=%b timeout=%b wait=%0d want 0/0/1",
                     fd_seen, rx_timeout, rx_wait);
        end
        vectors++;
        if (rx_bytes !== 80'hA5_CAFEF00D_00000001_C8) begin
            miscompares++;
            $display("FAIL midrst_bytes got %h want a5cafef00d00000001c8",
                     rx_bytes);
        end
        vectors++;
        if (!rx_frame_ok || rx_fd_end !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_frame ok=%b done=%b want 1/1",
                     rx_frame_ok, rx_fd_end);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bits();
        test_hold();
        test_drops();
        test_done_edge();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
